// File: rtl/clock_rate_meter_if.sv
// Control and result handshake bundle for clock_rate_meter.
// The master side requests windows and consumes results; the slave is the meter.
interface clock_rate_meter_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic             continuous;
  logic             result_ready;
  logic             result_valid;
  logic [CNT_W-1:0] edge_count;
  logic             overflow;
  logic             busy;

  modport master (
    output start, continuous, result_ready,
    input  result_valid, edge_count, overflow, busy
  );

  modport slave (
    input  start, continuous, result_ready,
    output result_valid, edge_count, overflow, busy
  );
endinterface

// File: rtl/clock_rate_meter.sv
// Gated edge counter: counts synchronized rising edges of meas_in over a fixed
// window of GATE_CYCLES clk cycles and holds the count until it is accepted.
module clock_rate_meter #(
  parameter int GATE_CYCLES = 1000,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                meas_in,
  clock_rate_meter_if.slave   bus
);

  localparam int GC_W = $clog2(GATE_CYCLES);
  localparam logic [GC_W-1:0] GATE_LOAD = GC_W'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, GATE, HOLD} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   meas_dly_q;
  logic [GC_W-1:0]        gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0]       acc_q, acc_d;
  logic                   ovf_q, ovf_d;
  logic [CNT_W-1:0]       edge_count_q, edge_count_d;
  logic                   overflow_q, overflow_d;

  logic                   edge_pulse;
  logic [CNT_W:0]         inc;
  logic [CNT_W-1:0]       acc_nxt;
  logic                   ovf_nxt;

  // MSB flags an attempted increment past all-ones; the count itself sticks.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return {1'b1, v};
    else    return {1'b0, v + 1'b1};
  endfunction

  assign edge_pulse = sync_q[SYNC_STAGES-1] & ~meas_dly_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sync_q       <= '0;
      meas_dly_q   <= 1'b0;
      gate_cnt_q   <= '0;
      acc_q        <= '0;
      ovf_q        <= 1'b0;
      edge_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= {sync_q[SYNC_STAGES-2:0], meas_in};
      meas_dly_q   <= sync_q[SYNC_STAGES-1];
      gate_cnt_q   <= gate_cnt_d;
      acc_q        <= acc_d;
      ovf_q        <= ovf_d;
      edge_count_q <= edge_count_d;
      overflow_q   <= overflow_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    gate_cnt_d   = gate_cnt_q;
    acc_d        = acc_q;
    ovf_d        = ovf_q;
    edge_count_d = edge_count_q;
    overflow_d   = overflow_q;

    inc     = sat_inc(acc_q);
    acc_nxt = edge_pulse ? inc[CNT_W-1:0] : acc_q;
    ovf_nxt = ovf_q | (edge_pulse & inc[CNT_W]);

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = GATE;
          gate_cnt_d = GATE_LOAD;
          acc_d      = '0;
          ovf_d      = 1'b0;
        end
      end
      GATE: begin
        acc_d      = acc_nxt;
        ovf_d      = ovf_nxt;
        gate_cnt_d = gate_cnt_q - 1'b1;
        // The final gate cycle's edge is part of the published result.
        if (gate_cnt_q == '0) begin
          state_d      = HOLD;
          edge_count_d = acc_nxt;
          overflow_d   = ovf_nxt;
        end
      end
      HOLD: begin
        if (bus.result_ready) begin
          if (bus.continuous) begin
            state_d    = GATE;
            gate_cnt_d = GATE_LOAD;
            acc_d      = '0;
            ovf_d      = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.result_valid = (state_q == HOLD);
  assign bus.busy         = (state_q != IDLE);
  assign bus.edge_count   = edge_count_q;
  assign bus.overflow     = overflow_q;

endmodule

// File: tb/tb_clock_rate_meter.sv
// Directed bench for clock_rate_meter: three instances (normal, narrow counter,
// long window) driven from one free-running divider and a shared control set.
module tb_clock_rate_meter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] div = '0;
  int          mode0, mode1, tap2, sel;
  logic        start_drv, cont_drv, ready_drv;
  logic        meas0, meas1, meas2;
  int          checks = 0;
  int          errors = 0;

  clock_rate_meter_if #(.CNT_W(32)) if0 ();
  clock_rate_meter_if #(.CNT_W(4))  if1 ();
  clock_rate_meter_if #(.CNT_W(32)) if2 ();

  clock_rate_meter #(.GATE_CYCLES(100),  .CNT_W(32), .SYNC_STAGES(2)) u0 (
    .clk(clk), .rst_n(rst_n), .meas_in(meas0), .bus(if0));
  clock_rate_meter #(.GATE_CYCLES(100),  .CNT_W(4),  .SYNC_STAGES(2)) u1 (
    .clk(clk), .rst_n(rst_n), .meas_in(meas1), .bus(if1));
  clock_rate_meter #(.GATE_CYCLES(1024), .CNT_W(32), .SYNC_STAGES(2)) u2 (
    .clk(clk), .rst_n(rst_n), .meas_in(meas2), .bus(if2));

  // Divider advances on the falling edge so taps are stable at every rising edge.
  initial forever begin
    @(negedge clk);
    div = div + 16'd1;
  end

  function automatic logic pick(input int m, input logic [15:0] d);
    case (m)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return d[0];
      default: return d[1];
    endcase
  endfunction

  assign meas0 = pick(mode0, div);
  assign meas1 = pick(mode1, div);
  assign meas2 = div[tap2[3:0]];

  assign if0.start        = start_drv & (sel == 0);
  assign if1.start        = start_drv & (sel == 1);
  assign if2.start        = start_drv & (sel == 2);
  assign if0.result_ready = ready_drv & (sel == 0);
  assign if1.result_ready = ready_drv & (sel == 1);
  assign if2.result_ready = ready_drv & (sel == 2);
  assign if0.continuous   = cont_drv;
  assign if1.continuous   = cont_drv;
  assign if2.continuous   = cont_drv;

  logic        obs_valid, obs_busy, obs_ovf;
  logic [31:0] obs_cnt;
  always_comb begin
    obs_valid = if0.result_valid;
    obs_busy  = if0.busy;
    obs_ovf   = if0.overflow;
    obs_cnt   = if0.edge_count;
    if (sel == 1) begin
      obs_valid = if1.result_valid;
      obs_busy  = if1.busy;
      obs_ovf   = if1.overflow;
      obs_cnt   = 32'(if1.edge_count);
    end else if (sel == 2) begin
      obs_valid = if2.result_valid;
      obs_busy  = if2.busy;
      obs_ovf   = if2.overflow;
      obs_cnt   = if2.edge_count;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (dut %0d): got %0d, expected %0d", name, sel, act, exp);
    end
  endtask

  // Optionally pulses start; then tracks the window from its first gate cycle.
  task automatic run_window(input string nm, input bit do_start, input int exp_lat,
                            input logic [31:0] exp_cnt, input logic exp_ovf);
    int lat;
    if (do_start) begin
      @(negedge clk); start_drv = 1'b1;
      @(negedge clk); start_drv = 1'b0;
    end
    lat = 1;
    check({nm, " busy in gate"}, 32'(obs_busy), 32'd1);
    while (!obs_valid && lat < exp_lat + 20) begin
      @(negedge clk);
      lat++;
    end
    check({nm, " latency"}, 32'(lat), 32'(exp_lat));
    check({nm, " edge_count"}, obs_cnt, exp_cnt);
    check({nm, " overflow"}, 32'(obs_ovf), 32'(exp_ovf));
  endtask

  task automatic handshake(input string nm, input logic cont);
    @(negedge clk); ready_drv = 1'b1; cont_drv = cont;
    @(negedge clk); ready_drv = 1'b0; cont_drv = 1'b0;
    check({nm, " valid after accept"}, 32'(obs_valid), 32'd0);
    check({nm, " busy after accept"}, 32'(obs_busy), 32'(cont));
  endtask

  typedef struct {
    int          mode;
    logic [31:0] exp_cnt;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[5];
  int   sweep_exp[7];

  initial begin
    vecs[0] = '{mode: 3, exp_cnt: 32'd25, exp_ovf: 1'b0};
    vecs[1] = '{mode: 0, exp_cnt: 32'd0,  exp_ovf: 1'b0};
    vecs[2] = '{mode: 1, exp_cnt: 32'd0,  exp_ovf: 1'b0};
    vecs[3] = '{mode: 2, exp_cnt: 32'd50, exp_ovf: 1'b0};
    vecs[4] = '{mode: 3, exp_cnt: 32'd25, exp_ovf: 1'b0};
    sweep_exp = '{0, 256, 128, 64, 32, 16, 8};

    rst_n = 1'b0; sel = 0; mode0 = 0; mode1 = 0; tap2 = 1;
    start_drv = 1'b0; cont_drv = 1'b0; ready_drv = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check("reset valid", 32'(obs_valid), 32'd0);
      check("reset busy",  32'(obs_busy),  32'd0);
      check("reset count", obs_cnt,        32'd0);
      check("reset ovf",   32'(obs_ovf),   32'd0);
    end
    sel = 0;
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      mode0 = vecs[i].mode;
      repeat (6) @(negedge clk);
      run_window($sformatf("vec%0d", i), 1'b1, 101, vecs[i].exp_cnt, vecs[i].exp_ovf);
      handshake($sformatf("vec%0d", i), 1'b0);
    end

    // Result held while the consumer stalls; start pulses must not disturb it.
    mode0 = 3;
    run_window("hold", 1'b1, 101, 32'd25, 1'b0);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      start_drv = (i % 7 == 0);
      check("hold valid", 32'(obs_valid), 32'd1);
      check("hold count", obs_cnt,        32'd25);
      check("hold busy",  32'(obs_busy),  32'd1);
    end
    start_drv = 1'b0;
    handshake("hold", 1'b1);
    run_window("cont", 1'b0, 101, 32'd25, 1'b0);
    handshake("cont", 1'b0);

    sel = 1; mode1 = 2;
    repeat (6) @(negedge clk);
    run_window("sat", 1'b1, 101, 32'd15, 1'b1);
    mode1 = 0;
    repeat (6) @(negedge clk);
    handshake("sat", 1'b1);
    run_window("after sat", 1'b0, 101, 32'd0, 1'b0);
    handshake("after sat", 1'b0);

    // Reset pulse in the middle of a gate window.
    sel = 0; mode0 = 3;
    @(negedge clk); start_drv = 1'b1;
    @(negedge clk); start_drv = 1'b0;
    repeat (48) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    check("midreset valid", 32'(obs_valid), 32'd0);
    check("midreset busy",  32'(obs_busy),  32'd0);
    check("midreset count", obs_cnt,        32'd0);
    check("midreset ovf",   32'(obs_ovf),   32'd0);
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (obs_valid || obs_busy) seen = 1'b1;
      end
      check("no result without start", 32'(seen), 32'd0);
    end
    run_window("post reset", 1'b1, 101, 32'd25, 1'b0);
    handshake("post reset", 1'b0);

    sel = 2;
    for (int n = 1; n <= 6; n++) begin
      tap2 = n;
      repeat (6) @(negedge clk);
      run_window($sformatf("tap%0d", n), 1'b1, 1025, 32'(sweep_exp[n]), 1'b0);
      handshake($sformatf("tap%0d", n), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
